main_control_fsm: RTL and testbench

//  Multicycle RV32I controller for datapath_main. Sequences fetch/decode/execute/memory/writeback by

---
 rtl/main_control_fsm_pkg.sv | 54 +++++
 rtl/main_control_fsm_alu_decoder.sv | 49 ++++
 rtl/main_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_main_control_fsm.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, ALU ops and mux selects.
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StAluWb, StBranch, StJal, StJalr, StJalrPc, StLui, StAuipc, StHalt
  } state_e;

  // How the ALU decoder should interpret funct3/funct7 in the current state.
  typedef enum logic [2:0] {
    ClsAdd, ClsR, ClsI, ClsBranch, ClsPassB
  } alu_cls_e;

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpR      = 7'h33;
  localparam logic [6:0] OpI      = 7'h13;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSll   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluSlt   = 4'd8;
  localparam logic [3:0] AluSltu  = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmU = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  localparam logic [1:0] SrcAOldPc = 2'd0;
  localparam logic [1:0] SrcAPc    = 2'd1;
  localparam logic [1:0] SrcAReg   = 2'd2;

  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBImm  = 2'd1;
  localparam logic [1:0] SrcBFour = 2'd2;

  localparam logic [2:0] OutAluReg = 3'd0;
  localparam logic [2:0] OutAluOut = 3'd1;
  localparam logic [2:0] OutData   = 3'd2;

endpackage

// File: rtl/main_control_fsm_alu_decoder.sv
// Combinational ALU operation select and branch resolution from state class and funct fields.
module main_control_fsm_alu_decoder
  import main_control_fsm_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       zero_i,
  input  logic       lt_i,
  output logic [3:0] alu_ctrl_o,
  output logic       taken_o,
  output logic       br_bad_o
);

  always_comb begin
    alu_ctrl_o = AluAdd;
    taken_o    = 1'b0;
    br_bad_o   = 1'b0;
    case (cls_i)
      ClsR, ClsI: begin
        case (funct3_i)
          // Immediate form has no SUB: funct7 there is part of the immediate.
          3'b000:  alu_ctrl_o = (cls_i == ClsR && funct7_5_i) ? AluSub : AluAdd;
          3'b001:  alu_ctrl_o = AluSll;
          3'b010:  alu_ctrl_o = AluSlt;
          3'b011:  alu_ctrl_o = AluSltu;
          3'b100:  alu_ctrl_o = AluXor;
          3'b101:  alu_ctrl_o = funct7_5_i ? AluSra : AluSrl;
          3'b110:  alu_ctrl_o = AluOr;
          default: alu_ctrl_o = AluAnd;
        endcase
      end
      ClsBranch: begin
        case (funct3_i)
          3'b000: begin alu_ctrl_o = AluSub;  taken_o = zero_i;  end
          3'b001: begin alu_ctrl_o = AluSub;  taken_o = ~zero_i; end
          3'b100: begin alu_ctrl_o = AluSlt;  taken_o = lt_i;    end
          3'b101: begin alu_ctrl_o = AluSlt;  taken_o = ~lt_i;   end
          3'b110: begin alu_ctrl_o = AluSltu; taken_o = lt_i;    end
          3'b111: begin alu_ctrl_o = AluSltu; taken_o = ~lt_i;   end
          default: begin alu_ctrl_o = AluSub; br_bad_o = 1'b1;   end
        endcase
      end
      ClsPassB: alu_ctrl_o = AluPassB;
      default:  alu_ctrl_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle RV32I controller: Moore state sequencing of fetch/decode/execute/memory/writeback,
// halting permanently (until reset) on ECALL/EBREAK or any unrecognised opcode.
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero_flag,
  input  logic       alu_lt,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       output_en,
  output logic [2:0] out_mux_sel,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [3:0] alu_ctrl,
  output logic       halted
);

  state_e     state_q, state_d;
  alu_cls_e   alu_cls;
  logic [3:0] dec_alu;
  logic       dec_taken;
  logic       dec_br_bad;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  main_control_fsm_alu_decoder u_alu_decoder (
    .cls_i      (alu_cls),
    .funct3_i   (funct3),
    .funct7_5_i (funct7[5]),
    .zero_i     (zero_flag),
    .lt_i       (alu_lt),
    .alu_ctrl_o (dec_alu),
    .taken_o    (dec_taken),
    .br_bad_o   (dec_br_bad)
  );

  always_comb begin
    alu_cls = ClsAdd;
    case (state_q)
      StExecR:  alu_cls = ClsR;
      StExecI:  alu_cls = ClsI;
      StBranch: alu_cls = ClsBranch;
      StLui:    alu_cls = ClsPassB;
      default:  alu_cls = ClsAdd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StHalt;
        endcase
      end
      StMemAdr:           state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead:          state_d = StMemWb;
      StMemWb:            state_d = StFetch;
      StMemWrite:         state_d = StFetch;
      StExecR, StExecI:   state_d = StAluWb;
      StAluWb:            state_d = StFetch;
      StBranch:           state_d = dec_br_bad ? StHalt : StFetch;
      StJal:              state_d = StAluWb;
      StJalr:             state_d = StJalrPc;
      StJalrPc:           state_d = StAluWb;
      StLui, StAuipc:     state_d = StAluWb;
      default:            state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    adr_src       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    out_mux_sel   = OutAluReg;
    imm_sel       = ImmI;
    alu_src_a_sel = SrcAOldPc;
    alu_src_b_sel = SrcBReg;
    halted        = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write      = 1'b1;
        pc_write      = 1'b1;
        out_mux_sel   = OutAluOut;
        alu_src_a_sel = SrcAPc;
        alu_src_b_sel = SrcBFour;
      end
      StDecode: begin
        // Speculative branch/jump target, latched into alu_reg for the next state.
        imm_sel       = (opcode == OpJal) ? ImmJ : ImmB;
        alu_src_b_sel = SrcBImm;
      end
      StMemAdr: begin
        imm_sel       = (opcode == OpStore) ? ImmS : ImmI;
        alu_src_a_sel = SrcAReg;
        alu_src_b_sel = SrcBImm;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        out_mux_sel = OutData;
        reg_write   = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: alu_src_a_sel = SrcAReg;
      StExecI: begin
        alu_src_a_sel = SrcAReg;
        alu_src_b_sel = SrcBImm;
      end
      StAluWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a_sel = SrcAReg;
        pc_write      = dec_taken;
      end
      StJal, StJalrPc: begin
        pc_write      = 1'b1;
        alu_src_b_sel = SrcBFour;
      end
      StJalr: begin
        alu_src_a_sel = SrcAReg;
        alu_src_b_sel = SrcBImm;
      end
      StLui: begin
        imm_sel       = ImmU;
        alu_src_b_sel = SrcBImm;
      end
      StAuipc: begin
        imm_sel       = ImmU;
        alu_src_b_sel = SrcBImm;
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
    alu_ctrl = dec_alu;
    // Reset aborts any instruction in flight: nothing may be written while it is held.
    if (rst) begin
      adr_src       = 1'b0;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      out_mux_sel   = 3'd0;
      imm_sel       = 3'd0;
      alu_src_a_sel = 2'd0;
      alu_src_b_sel = 2'd0;
      alu_ctrl      = 4'd0;
      halted        = 1'b0;
    end
    output_en = reg_write;
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench: each cycle's expected control word is queued by the stimulus and checked
// by an independent monitor on the falling edge.
module tb_main_control_fsm;

  typedef logic [20:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero_flag;
  logic       alu_lt;
  logic       adr_src, pc_write, ir_write, mem_write, reg_write, output_en, halted;
  logic [2:0] out_mux_sel, imm_sel;
  logic [1:0] alu_src_a_sel, alu_src_b_sel;
  logic [3:0] alu_ctrl;

  vec_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  main_control_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .zero_flag     (zero_flag),
    .alu_lt        (alu_lt),
    .adr_src       (adr_src),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .output_en     (output_en),
    .out_mux_sel   (out_mux_sel),
    .imm_sel       (imm_sel),
    .alu_src_a_sel (alu_src_a_sel),
    .alu_src_b_sel (alu_src_b_sel),
    .alu_ctrl      (alu_ctrl),
    .halted        (halted)
  );

  // Field order: adr, pc_write, ir_write, mem_write, reg_write, out_sel, imm, a, b, alu, halted.
  function automatic vec_t mk(input logic adr, input logic pcw, input logic irw, input logic mw,
                              input logic rw, input logic [2:0] out, input logic [2:0] imm,
                              input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                              input logic h);
    return {adr, pcw, irw, mw, rw, rw, out, imm, a, b, alu, h};
  endfunction

  vec_t e_fetch, e_dec_b, e_dec_j, e_wb, e_zero, e_halt;

  always @(negedge clk) begin
    vec_t  e;
    vec_t  got;
    string nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {adr_src, pc_write, ir_write, mem_write, reg_write, output_en, out_mux_sel, imm_sel,
             alu_src_a_sel, alu_src_b_sel, alu_ctrl, halted};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm, got, e);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, input logic lt, input vec_t e);
    rst = r; opcode = op; funct3 = f3; funct7 = f7; zero_flag = z; alu_lt = lt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input string nm, input logic [6:0] op, input logic [2:0] f3,
                    input logic [6:0] f7, input vec_t dec);
    step({nm, "_fetch"}, 1'b0, op, f3, f7, 1'b0, 1'b0, e_fetch);
    step({nm, "_decode"}, 1'b0, op, f3, f7, 1'b0, 1'b0, dec);
  endtask

  initial begin
    e_fetch = mk(0, 1, 1, 0, 0, 3'd1, 3'd0, 2'd1, 2'd2, 4'd0, 0);
    e_dec_b = mk(0, 0, 0, 0, 0, 3'd0, 3'd2, 2'd0, 2'd1, 4'd0, 0);
    e_dec_j = mk(0, 0, 0, 0, 0, 3'd0, 3'd4, 2'd0, 2'd1, 4'd0, 0);
    e_wb    = mk(0, 0, 0, 0, 1, 3'd0, 3'd0, 2'd0, 2'd0, 4'd0, 0);
    e_zero  = '0;
    e_halt  = mk(0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 2'd0, 4'd0, 1);
    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; zero_flag = 1'b0; alu_lt = 1'b0;
    @(posedge clk);
    #1;

    step("rst0", 1, 7'h00, 0, 0, 0, 0, e_zero);
    step("rst1", 1, 7'h00, 0, 0, 0, 0, e_zero);

    fd("add", 7'h33, 3'd0, 7'h00, e_dec_b);
    step("add_ex", 0, 7'h33, 3'd0, 7'h00, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd0, 0));
    step("add_wb", 0, 7'h33, 3'd0, 7'h00, 0, 0, e_wb);

    fd("sub", 7'h33, 3'd0, 7'h20, e_dec_b);
    step("sub_ex", 0, 7'h33, 3'd0, 7'h20, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd1, 0));
    step("sub_wb", 0, 7'h33, 3'd0, 7'h20, 0, 0, e_wb);

    fd("srai", 7'h13, 3'd5, 7'h20, e_dec_b);
    step("srai_ex", 0, 7'h13, 3'd5, 7'h20, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd7, 0));
    step("srai_wb", 0, 7'h13, 3'd5, 7'h20, 0, 0, e_wb);

    fd("addi", 7'h13, 3'd0, 7'h20, e_dec_b);
    step("addi_ex", 0, 7'h13, 3'd0, 7'h20, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 0));
    step("addi_wb", 0, 7'h13, 3'd0, 7'h20, 0, 0, e_wb);

    fd("slti", 7'h13, 3'd2, 7'h00, e_dec_b);
    step("slti_ex", 0, 7'h13, 3'd2, 7'h00, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd8, 0));
    step("slti_wb", 0, 7'h13, 3'd2, 7'h00, 0, 0, e_wb);

    fd("lw", 7'h03, 3'd2, 7'h00, e_dec_b);
    step("lw_adr", 0, 7'h03, 3'd2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 4'd0, 0));
    step("lw_rd", 0, 7'h03, 3'd2, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("lw_wb", 0, 7'h03, 3'd2, 0, 0, 0, mk(0, 0, 0, 0, 1, 3'd2, 0, 0, 0, 0, 0));

    fd("sw", 7'h23, 3'd2, 7'h00, e_dec_b);
    step("sw_adr", 0, 7'h23, 3'd2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, 2'd1, 4'd0, 0));
    step("sw_wr", 0, 7'h23, 3'd2, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    fd("beq", 7'h63, 3'd0, 7'h00, e_dec_b);
    step("beq_br", 0, 7'h63, 3'd0, 0, 1, 0, mk(0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd1, 0));
    fd("bne", 7'h63, 3'd1, 7'h00, e_dec_b);
    step("bne_br", 0, 7'h63, 3'd1, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd1, 0));
    fd("blt", 7'h63, 3'd4, 7'h00, e_dec_b);
    step("blt_br", 0, 7'h63, 3'd4, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd8, 0));
    fd("bltu", 7'h63, 3'd6, 7'h00, e_dec_b);
    step("bltu_br", 0, 7'h63, 3'd6, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd9, 0));

    fd("jal", 7'h6F, 3'd0, 7'h00, e_dec_j);
    step("jal_pc", 0, 7'h6F, 3'd0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 4'd0, 0));
    step("jal_wb", 0, 7'h6F, 3'd0, 0, 0, 0, e_wb);

    fd("jalr", 7'h67, 3'd0, 7'h00, e_dec_b);
    step("jalr_adr", 0, 7'h67, 3'd0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 4'd0, 0));
    step("jalr_pc", 0, 7'h67, 3'd0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 4'd0, 0));
    step("jalr_wb", 0, 7'h67, 3'd0, 0, 0, 0, e_wb);

    fd("lui", 7'h37, 3'd0, 7'h00, e_dec_b);
    step("lui_ex", 0, 7'h37, 3'd0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd3, 2'd0, 2'd1, 4'd10, 0));
    step("lui_wb", 0, 7'h37, 3'd0, 0, 0, 0, e_wb);

    fd("auipc", 7'h17, 3'd0, 7'h00, e_dec_b);
    step("auipc_ex", 0, 7'h17, 3'd0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd3, 2'd0, 2'd1, 4'd0, 0));
    step("auipc_wb", 0, 7'h17, 3'd0, 0, 0, 0, e_wb);

    fd("ecall", 7'h73, 3'd0, 7'h00, e_dec_b);
    for (int i = 0; i < 20; i++) begin
      step("ecall_halt", 0, 7'h33, 3'd0, 0, 1, 1, e_halt);
    end

    step("rst2", 1, 7'h23, 0, 0, 0, 0, e_zero);
    step("rst3", 1, 7'h23, 0, 0, 0, 0, e_zero);

    fd("swabort", 7'h23, 3'd2, 7'h00, e_dec_b);
    step("swabort_adr", 0, 7'h23, 3'd2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, 2'd1, 4'd0, 0));
    step("swabort_rst", 1, 7'h23, 3'd2, 0, 0, 0, e_zero);

    fd("ill7f", 7'h7F, 3'd0, 7'h00, e_dec_b);
    for (int i = 0; i < 3; i++) begin
      step("ill7f_halt", 0, 7'h03, 3'd0, 0, 0, 0, e_halt);
    end

    step("rst4", 1, 7'h00, 0, 0, 0, 0, e_zero);
    fd("bbad", 7'h63, 3'd2, 7'h00, e_dec_b);
    step("bbad_br", 0, 7'h63, 3'd2, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'd1, 0));
    step("bbad_halt", 0, 7'h63, 3'd2, 0, 1, 1, e_halt);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
